// File: rtl/vga_object_compositor_pkg.sv
// Shared types and helpers for the VGA object compositor: object record,
// commit FSM states and the saturating edge computation.
package vga_object_compositor_pkg;

   // Storage width for coordinates; the top-level COORD_W must not exceed it.
   localparam int OBJ_CW = 16;

   typedef struct packed {
      logic [OBJ_CW-1:0] left;
      logic [OBJ_CW-1:0] right;
      logic [OBJ_CW-1:0] top;
      logic [OBJ_CW-1:0] bottom;
      logic [2:0]        color;
      logic              valid;
   } obj_t;

   localparam int OBJ_W = $bits(obj_t);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } commit_state_t;

   // Far edge = start + size - 1, clamped to limit - 1 when it overshoots the screen.
   function automatic logic [OBJ_CW-1:0] sat_edge(input logic [OBJ_CW-1:0] start,
                                                  input logic [OBJ_CW-1:0] size,
                                                  input logic [OBJ_CW-1:0] limit);
      logic [OBJ_CW:0] w_end;
      w_end = {1'b0, start} + {1'b0, size} - {{OBJ_CW{1'b0}}, 1'b1};
      if (w_end >= {1'b0, limit}) return limit - OBJ_CW'(1);
      return w_end[OBJ_CW-1:0];
   endfunction

endpackage

// File: rtl/vga_obj_hit.sv
// One object's active-bank entry and its registered (stage-1) hit comparator.
module vga_obj_hit
   import vga_object_compositor_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_load,
   input  logic [OBJ_W-1:0]  i_shadow,
   input  logic [OBJ_CW-1:0] i_x,
   input  logic [OBJ_CW-1:0] i_y,
   output logic              o_hit_p1,
   output logic [2:0]        o_color
);

   obj_t r_active;
   logic r_hit_p1;
   logic w_hit;

   always_comb begin
      w_hit = r_active.valid
              && (i_x >= r_active.left) && (i_x <= r_active.right)
              && (i_y >= r_active.top)  && (i_y <= r_active.bottom);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_active.valid <= 1'b0;
         r_hit_p1       <= 1'b0;
      end else begin
         if (i_load) r_active <= obj_t'(i_shadow);
         r_hit_p1 <= w_hit;
      end
   end

   assign o_hit_p1 = r_hit_p1;
   assign o_color  = r_active.color;

endmodule

// File: rtl/vga_object_compositor.sv
// Double-buffered rectangle compositor with fixed priority (lowest index on top)
// and per-frame bird (object 0) collision reporting.
module vga_object_compositor
   import vga_object_compositor_pkg::*;
#(
   parameter int         N_OBJ    = 4,
   parameter int         COORD_W  = 10,
   parameter int         H_ACTIVE = 640,
   parameter int         V_ACTIVE = 480,
   parameter logic [2:0] BG_COLOR = 3'b000,
   localparam int        IDX_W    = (N_OBJ > 2) ? $clog2(N_OBJ) : 1
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic [COORD_W-1:0] wr_w,
   input  logic [COORD_W-1:0] wr_h,
   input  logic [2:0]         wr_color,
   input  logic               wr_visible,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] counter_x,
   input  logic [COORD_W-1:0] counter_y,
   input  logic               de_in,
   input  logic               hsync_in,
   input  logic               vsync_in,
   output logic               vga_r,
   output logic               vga_g,
   output logic               vga_b,
   output logic               de_out,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic [N_OBJ-1:0]   hit_mask,
   output logic               collision,
   output logic               collision_sticky,
   input  logic               collision_clr
);

   localparam logic [OBJ_CW-1:0] H_LIM = OBJ_CW'(H_ACTIVE);
   localparam logic [OBJ_CW-1:0] V_LIM = OBJ_CW'(V_ACTIVE);

   obj_t              r_shadow [N_OBJ];
   commit_state_t     r_state, w_state_nxt;
   obj_t              w_wr_obj;
   logic              w_accept, w_commit, w_coll_set;
   logic [OBJ_CW-1:0] w_wr_x, w_wr_y, w_wr_w, w_wr_h, w_px, w_py;
   logic [N_OBJ-1:0]  w_hit_p1;
   logic [2:0]        w_color [N_OBJ];
   logic [2:0]        w_pix_color;
   logic              r_vld_p1, r_hs_p1, r_vs_p1;
   logic              r_vld_p2, r_hs_p2, r_vs_p2;
   logic [2:0]        r_rgb_p2;
   logic [N_OBJ-1:0]  r_hit_p2;
   logic              r_coll_acc, r_coll, r_coll_sticky;

   assign w_wr_x   = OBJ_CW'(wr_x);
   assign w_wr_y   = OBJ_CW'(wr_y);
   assign w_wr_w   = OBJ_CW'(wr_w);
   assign w_wr_h   = OBJ_CW'(wr_h);
   assign w_px     = OBJ_CW'(counter_x);
   assign w_py     = OBJ_CW'(counter_y);
   assign w_accept = wr_en && (32'(wr_idx) < 32'(N_OBJ));

   always_comb begin
      w_wr_obj.left   = w_wr_x;
      w_wr_obj.right  = sat_edge(w_wr_x, w_wr_w, H_LIM);
      w_wr_obj.top    = w_wr_y;
      w_wr_obj.bottom = sat_edge(w_wr_y, w_wr_h, V_LIM);
      w_wr_obj.color  = wr_color;
      w_wr_obj.valid  = wr_visible && (w_wr_w != '0) && (w_wr_h != '0)
                        && (w_wr_x < H_LIM) && (w_wr_y < V_LIM);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_OBJ; i++) begin
         if (!reset_n)                              r_shadow[i].valid <= 1'b0;
         else if (w_accept && wr_idx == IDX_W'(i))  r_shadow[i] <= w_wr_obj;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // The copy samples shadow before this cycle's write, so a coincident write stays pending.
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE:    if (w_accept) w_state_nxt = ST_PENDING;
         ST_PENDING: if (frame_start) begin
            w_commit = 1'b1;
            if (!w_accept) w_state_nxt = ST_IDLE;
         end
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Stage 1: per-object hit comparators, syncs delayed alongside
   genvar g;
   generate
      for (g = 0; g < N_OBJ; g++) begin : g_obj
         vga_obj_hit u_hit (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_load   (w_commit),
            .i_shadow (r_shadow[g]),
            .i_x      (w_px),
            .i_y      (w_py),
            .o_hit_p1 (w_hit_p1[g]),
            .o_color  (w_color[g])
         );
      end
   endgenerate

   always_comb begin
      w_pix_color = BG_COLOR;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (w_hit_p1[i]) w_pix_color = w_color[i];
      end
   end

   assign w_coll_set = r_vld_p1 && w_hit_p1[0] && (|w_hit_p1[N_OBJ-1:1]);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_vld_p1 <= 1'b0;
         r_hs_p1  <= 1'b0;
         r_vs_p1  <= 1'b0;
         r_vld_p2 <= 1'b0;
         r_hs_p2  <= 1'b0;
         r_vs_p2  <= 1'b0;
         r_rgb_p2 <= 3'b000;
         r_hit_p2 <= '0;
      end else begin
         r_vld_p1 <= de_in;
         r_hs_p1  <= hsync_in;
         r_vs_p1  <= vsync_in;
         // Stage 2: priority colour, blanked outside the active area
         r_rgb_p2 <= w_pix_color & {3{r_vld_p1}};
         r_hit_p2 <= w_hit_p1;
         r_vld_p2 <= r_vld_p1;
         r_hs_p2  <= r_hs_p1;
         r_vs_p2  <= r_vs_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_coll_acc    <= 1'b0;
         r_coll        <= 1'b0;
         r_coll_sticky <= 1'b0;
      end else begin
         if (frame_start) begin
            r_coll     <= r_coll_acc;
            r_coll_acc <= w_coll_set;
         end else begin
            r_coll_acc <= r_coll_acc | w_coll_set;
         end
         if (frame_start && r_coll_acc) r_coll_sticky <= 1'b1;
         else if (collision_clr)         r_coll_sticky <= 1'b0;
      end
   end

   assign {vga_r, vga_g, vga_b} = r_rgb_p2;
   assign hit_mask              = r_hit_p2;
   assign de_out                = r_vld_p2;
   assign hsync_out             = r_hs_p2;
   assign vsync_out             = r_vs_p2;
   assign collision             = r_coll;
   assign collision_sticky      = r_coll_sticky;

endmodule

// File: doc/vga_object_compositor.md
# vga_object_compositor

Parametrised successor to the hard-coded bird/pipe rendering in the Flappy VGA top level. It holds N_OBJ rectangular objects, each with its own colour and visibility, and composites them per pixel with fixed priority. Object updates are double-buffered and committed only at frame boundaries, so the picture never tears. Each frame it also reports whether object 0 (the bird) overlapped any other object. It sits between hvsync_generator and the vga_r/g/b pins, and its collision flag feeds the game control logic.

## Interface
Parameters:
- N_OBJ, 4: number of objects. Must be ≥ 2. IDX_W = max(1, clog2(N_OBJ)).
- COORD_W, 10: width of all coordinates and sizes.
- H_ACTIVE, 640: visible width in pixels.
- V_ACTIVE, 480: visible height in pixels.
- BG_COLOR, 3'b000: {r,g,b} value driven where no object is hit.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write the shadow entry selected by wr_idx.
- wr_idx  in  IDX_W  object index. Writes with an index ≥ N_OBJ are ignored.
- wr_x, wr_y  in  COORD_W  top-left corner.
- wr_w, wr_h  in  COORD_W  size in pixels. A value of 0 makes the object invisible.
- wr_color  in  3  {r,g,b}.
- wr_visible  in  1  visibility bit.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- counter_x, counter_y  in  COORD_W  current pixel position.
- de_in, hsync_in, vsync_in  in  1  display-enable and sync signals from the generator.
- vga_r, vga_g, vga_b  out  1  registered colour outputs.
- de_out, hsync_out, vsync_out  out  1  inputs delayed to stay aligned with the colour outputs.
- hit_mask  out  N_OBJ  objects hit at the current output pixel.
- collision  out  1  result of the last completed frame.
- collision_sticky  out  1  latched collision; cleared only by collision_clr.
- collision_clr  in  1  clears collision_sticky.

## Operation
Shadow write, in the same cycle as wr_en:
- Left = wr_x, top = wr_y.
- Right = wr_x + wr_w − 1, computed at COORD_W+1 bits. Saturates to H_ACTIVE−1 on overflow or overshoot.
- Bottom = wr_y + wr_h − 1, saturated the same way to V_ACTIVE−1.
- Valid = wr_visible && w≠0 && h≠0 && wr_x < H_ACTIVE && wr_y < V_ACTIVE.

Commit FSM, with states IDLE and PENDING:
- Any accepted write moves IDLE → PENDING.
- frame_start while in PENDING copies the whole shadow bank into the active bank and returns to IDLE.
- frame_start while in IDLE does nothing.
- A write in the same cycle as frame_start is not part of that copy. It lands in shadow and the FSM stays (or re-enters) PENDING.

Compositing:
- Stage 1 registers hit[i] = valid_i && left_i ≤ x ≤ right_i && top_i ≤ y ≤ bottom_i, all inclusive. It also registers de, hsync and vsync.
- Stage 2 picks the lowest-index hit object's colour, else BG_COLOR. The colour is ANDed with the stage-1 de and registered. hit_mask is registered alongside it.

Collision:
- The per-frame accumulator sets when, in stage 2, de && hit[0] && |hit[N_OBJ−1:1].
- On frame_start: collision ← accumulator, the accumulator clears, and collision_sticky |= accumulator.
- collision_clr clears collision_sticky. If it coincides with a set event, the set wins.

Reset (reset_n low at a clk edge):
- Shadow and active banks become invalid.
- FSM returns to IDLE.
- All outputs go to 0, including the colour outputs (not BG_COLOR), hit_mask and both flags.
- Reset taken mid-frame leaves the screen blank until a write is followed by frame_start.

## Timing
- Pixel-to-output latency is exactly 2 clk cycles for colour, hit_mask and the delayed de/hsync/vsync.
- A shadow write at cycle t is visible on the output from the first pixel after the next frame_start at cycle > t.
- frame_start at cycle f updates collision at cycle f+1.
- Pixels that are still in the pipeline at frame_start count toward the next frame. frame_start falls in blank, so those pixels have de = 0 and cannot contribute.

## Structure
- Shared package holds the object record type {left, right, top, bottom, color, valid}, the FSM state enum, and the saturating edge function.
- One sub-module, vga_obj_hit: a single object's active-bank entry plus its hit comparator, instantiated N_OBJ times in a generate loop.

## Test plan
- Basic draw: write obj0 x=100 y=50 w=20 h=20 color=100, then frame_start. vga_r = 1 exactly for x∈[100,119], y∈[50,69], 2 cycles after the pixel; BG elsewhere.
- Priority: obj1 (010) and obj2 (001) overlap at x=200..239. The overlap shows 010, and hit_mask = 0110 there.
- Commit timing: move obj0 mid-frame. The old position is drawn until frame_start. A write in the frame_start cycle appears only after the following frame_start.
- Saturation: wr_x=630, w=50 gives right edge 639. wr_x=700 gives an invisible object. w=0 gives an invisible object.
- Collision: obj0 overlaps obj3 for one pixel. collision = 1 for the next frame only. collision_sticky stays 1 until collision_clr. Clear and set in the same cycle leaves sticky = 1.
- Reset mid-frame: pull reset_n low. All outputs are 0 the next cycle and the screen stays blank until a write followed by frame_start.
